// File: rtl/axi_aw_w_scheduler.sv
// Round-robin AW arbiter for one master write port. The W channel follows the
// order of accepted AWs through a small index FIFO, so write bursts never interleave.
module axi_aw_w_scheduler #(
  parameter int unsigned  NumIn     = 4,
  parameter int unsigned  FifoDepth = 4,
  parameter type          AwType    = logic,
  parameter type          WType     = logic,
  localparam int unsigned IdxW      = $clog2(NumIn),
  localparam int unsigned CntW      = $clog2(FifoDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic  [NumIn-1:0]    slv_aw_valid_i,
  input  AwType [NumIn-1:0]    slv_aw_i,
  output logic  [NumIn-1:0]    slv_aw_ready_o,
  output logic                 mst_aw_valid_o,
  output AwType                mst_aw_o,
  output logic  [IdxW-1:0]     mst_aw_idx_o,
  input  logic                 mst_aw_ready_i,
  input  logic  [NumIn-1:0]    slv_w_valid_i,
  input  WType  [NumIn-1:0]    slv_w_i,
  input  logic  [NumIn-1:0]    slv_w_last_i,
  output logic  [NumIn-1:0]    slv_w_ready_o,
  output logic                 mst_w_valid_o,
  output WType                 mst_w_o,
  output logic                 mst_w_last_o,
  input  logic                 mst_w_ready_i,
  output logic  [CntW-1:0]     w_usage_o
);

  localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    HOLD = 2'b10
  } state_e;

  state_e            state_q, state_d, fsm_next_s;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d, fsm_rr_ptr_s;
  logic [IdxW-1:0]   aw_idx_q, aw_idx_d, fsm_aw_idx_s;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   usage_q, usage_d;
  logic [IdxW-1:0]   mem_q [FifoDepth];
  logic [IdxW-1:0]   mem_d [FifoDepth];

  logic              rr_found_s;
  logic [IdxW-1:0]   rr_pick_s;
  logic [IdxW-1:0]   rr_next_s;
  logic              queue_full_s;
  logic              queue_empty_s;
  logic [IdxW-1:0]   w_idx_s;
  logic              fsm_push_s;
  logic              aw_push_s;
  logic              w_pop_s;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(FifoDepth - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = ptr + PtrW'(1);
    end
  endfunction

  assign queue_full_s  = (usage_q == CntW'(FifoDepth));
  assign queue_empty_s = (usage_q == CntW'(0));
  assign mst_aw_o      = slv_aw_i[aw_idx_q];
  assign mst_aw_idx_o  = aw_idx_q;
  assign w_usage_o     = usage_q;

  // First requesting index at or after rr_ptr, wrapping around.
  always_comb begin
    rr_found_s = 1'b0;
    rr_pick_s  = '0;
    for (int unsigned i = 0; i < NumIn; i++) begin
      logic [IdxW-1:0] cand;
      cand = IdxW'((32'(rr_ptr_q) + i) % NumIn);
      if (!rr_found_s && slv_aw_valid_i[cand]) begin
        rr_found_s = 1'b1;
        rr_pick_s  = cand;
      end else begin
        rr_found_s = rr_found_s;
      end
    end
    rr_next_s = IdxW'((32'(rr_pick_s) + 32'd1) % NumIn);
  end

  // AW FSM: grant in IDLE, forward the granted requester in HOLD.
  always_comb begin
    fsm_next_s     = state_q;
    fsm_rr_ptr_s   = rr_ptr_q;
    fsm_aw_idx_s   = aw_idx_q;
    fsm_push_s     = 1'b0;
    mst_aw_valid_o = 1'b0;
    slv_aw_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (rr_found_s && !queue_full_s) begin
          fsm_aw_idx_s = rr_pick_s;
          fsm_rr_ptr_s = rr_next_s;
          fsm_next_s   = HOLD;
        end else begin
          fsm_next_s   = IDLE;
        end
      end
      HOLD: begin
        mst_aw_valid_o           = slv_aw_valid_i[aw_idx_q];
        slv_aw_ready_o[aw_idx_q] = mst_aw_ready_i;
        if (slv_aw_valid_i[aw_idx_q] && mst_aw_ready_i) begin
          fsm_push_s = 1'b1;
          fsm_next_s = IDLE;
        end else begin
          fsm_next_s = HOLD;
        end
      end
      default: begin
        fsm_next_s = IDLE;
      end
    endcase
    state_d   = flush_i ? IDLE     : fsm_next_s;
    rr_ptr_d  = flush_i ? rr_ptr_q : fsm_rr_ptr_s;
    aw_idx_d  = flush_i ? aw_idx_q : fsm_aw_idx_s;
    aw_push_s = fsm_push_s && !flush_i;
  end

  // W channel is steered by the queue head; nothing passes while the queue is empty.
  always_comb begin
    w_idx_s       = mem_q[rd_ptr_q];
    mst_w_valid_o = 1'b0;
    mst_w_o       = '0;
    mst_w_last_o  = 1'b0;
    slv_w_ready_o = '0;
    if (!queue_empty_s) begin
      mst_w_valid_o          = slv_w_valid_i[w_idx_s];
      mst_w_o                = slv_w_i[w_idx_s];
      mst_w_last_o           = slv_w_last_i[w_idx_s];
      slv_w_ready_o[w_idx_s] = mst_w_ready_i;
    end else begin
      mst_w_valid_o = 1'b0;
    end
    w_pop_s = mst_w_valid_o && mst_w_ready_i && mst_w_last_o;
  end

  // Index queue bookkeeping; flush empties it but leaves stored entries stale.
  always_comb begin
    mem_d = mem_q;
    if (aw_push_s) begin
      mem_d[wr_ptr_q] = aw_idx_q;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    case ({aw_push_s, w_pop_s})
      2'b10:   usage_d = usage_q + CntW'(1);
      2'b01:   usage_d = usage_q - CntW'(1);
      default: usage_d = usage_q;
    endcase
    wr_ptr_d = aw_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = w_pop_s   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usage_d  = '0;
    end else begin
      usage_d  = usage_d;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      aw_idx_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
      for (int unsigned i = 0; i < FifoDepth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      aw_idx_q <= aw_idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usage_q  <= usage_d;
      mem_q    <= mem_d;
    end
  end

endmodule
